// File: rtl/bnn_feature_sequencer_if.sv
// Handshake and classifier-side signal bundle for bnn_feature_sequencer.
// master = sequencer side, slave = sample source / classifier / consumer side.
interface bnn_feature_sequencer_if #(
  parameter int FEAT_CNT  = 12,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 6,
  parameter int CNT_BITS  = 16
);
  localparam int PRED_BITS = $clog2(CLASS_CNT);

  logic                          in_valid;
  logic                          in_ready;
  logic [FEAT_BITS-1:0]          in_feat;
  logic [FEAT_CNT*FEAT_BITS-1:0] features;
  logic                          bnn_rst;
  logic [PRED_BITS-1:0]          bnn_prediction;
  logic                          out_valid;
  logic                          out_ready;
  logic [PRED_BITS-1:0]          out_class;
  logic [CNT_BITS-1:0]           done_cnt;

  modport master (
    input  in_valid, in_feat, bnn_prediction, out_ready,
    output in_ready, features, bnn_rst, out_valid, out_class, done_cnt
  );

  modport slave (
    output in_valid, in_feat, bnn_prediction, out_ready,
    input  in_ready, features, bnn_rst, out_valid, out_class, done_cnt
  );
endinterface

// File: rtl/bnn_feature_sequencer.sv
// Packs a feature stream onto the BNN classifier bus, pulses its restart, waits a
// fixed inference time and hands the captured prediction back over valid/ready.
module bnn_feature_sequencer #(
  parameter int FEAT_CNT     = 12,
  parameter int FEAT_BITS    = 4,
  parameter int CLASS_CNT    = 6,
  parameter int INFER_CYCLES = 48,
  parameter int CNT_BITS     = 16
) (
  input logic                     clk,
  input logic                     rst,
  bnn_feature_sequencer_if.master bus
);
  localparam int PRED_BITS = $clog2(CLASS_CNT);
  localparam int IDX_BITS  = $clog2(FEAT_CNT);
  localparam int WAIT_BITS = $clog2(INFER_CYCLES + 1);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [IDX_BITS-1:0]  LAST_IDX  = IDX_BITS'(FEAT_CNT - 1);
  localparam logic [WAIT_BITS-1:0] LAST_WAIT = WAIT_BITS'(INFER_CYCLES - 1);

  logic [1:0]                    r_state;
  logic [IDX_BITS-1:0]           r_idx;
  logic [WAIT_BITS-1:0]          r_wait;
  logic [FEAT_CNT*FEAT_BITS-1:0] r_features;
  logic                          r_bnn_rst;
  logic                          r_out_valid;
  logic [PRED_BITS-1:0]          r_out_class;
  logic [CNT_BITS-1:0]           r_done_cnt;
  logic                          w_in_ready;

  // NOTE: in_ready decodes state only, so no combinational path exists from in_valid back to it.
  assign w_in_ready = (r_state == S_LOAD);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_idx       <= '0;
      r_wait      <= '0;
      r_features  <= '0;
      r_bnn_rst   <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_class <= '0;
      r_done_cnt  <= '0;
    end else begin
      r_bnn_rst <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (bus.in_valid) begin
            r_features[r_idx*FEAT_BITS +: FEAT_BITS] <= bus.in_feat;
            if (r_idx == LAST_IDX) begin
              r_idx     <= '0;
              r_state   <= S_START;
              r_bnn_rst <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_BITS'(1);
            end
          end
        end
        S_START: begin
          r_wait  <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          // Prediction is sampled in the cycle the wait counter reaches INFER_CYCLES-1.
          if (r_wait == LAST_WAIT) begin
            r_out_class <= bus.bnn_prediction;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
          r_wait <= r_wait + WAIT_BITS'(1);
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + CNT_BITS'(1);
            r_state     <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.features  = r_features;
  assign bus.bnn_rst   = r_bnn_rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out_class = r_out_class;
  assign bus.done_cnt  = r_done_cnt;
endmodule

// File: tb/tb_bnn_feature_sequencer.sv
// Self-checking bench for bnn_feature_sequencer: a timestamp-level reference model is
// compared against the DUT every cycle, plus literal expectations for directed samples.
module tb_bnn_feature_sequencer;
  localparam int FC = 12;
  localparam int FB = 4;
  localparam int CC = 6;
  localparam int IC = 48;
  localparam int CB = 16;
  localparam int PB = $clog2(CC);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  bnn_feature_sequencer_if #(.FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(CC), .CNT_BITS(CB)) bus ();

  bnn_feature_sequencer #(
    .FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(CC), .INFER_CYCLES(IC), .CNT_BITS(CB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks sample progress by accepted-word count and cycle timestamps.
  int               cyc = 0;
  bit               m_load;
  int               m_idx;
  logic [FC*FB-1:0] m_feat;
  bit               m_ov;
  logic [PB-1:0]    m_class;
  logic [CB-1:0]    m_done;
  bit               m_brst;
  longint           t_ov;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_load  = 1'b1;
      m_idx   = 0;
      m_feat  = '0;
      m_ov    = 1'b0;
      m_class = '0;
      m_done  = '0;
      m_brst  = 1'b1;
      t_ov    = -1;
    end else begin
      m_brst = 1'b0;
      if (m_load) begin
        if (bus.in_valid) begin
          m_feat[m_idx*FB +: FB] = bus.in_feat;
          m_idx++;
          if (m_idx == FC) begin
            m_idx  = 0;
            m_load = 1'b0;
            m_brst = 1'b1;
            t_ov   = cyc + IC + 1;
          end
        end
      end else if (!m_ov) begin
        if (cyc == t_ov) begin
          m_ov    = 1'b1;
          m_class = bus.bnn_prediction;
        end
      end else if (bus.out_ready) begin
        m_ov   = 1'b0;
        m_done = m_done + 1'b1;
        m_load = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", bus.in_ready, m_load);
    check("bnn_rst", bus.bnn_rst, m_brst);
    check("out_valid", bus.out_valid, m_ov);
    check("out_class", bus.out_class, m_class);
    check("features", bus.features, m_feat);
    check("done_cnt", bus.done_cnt, m_done);
  end

  // Classifier stub: 0 = constant, 1 = cycle-indexed ramp, 2 = random each cycle.
  int            pred_mode  = 0;
  logic [PB-1:0] pred_const = PB'(3);

  always @(negedge clk) begin
    case (pred_mode)
      0:       bus.bnn_prediction = pred_const;
      1:       bus.bnn_prediction = PB'(cyc % CC);
      default: bus.bnn_prediction = PB'($urandom_range(CC - 1));
    endcase
  end

  int last_acc = 0;

  task automatic send_word(input logic [FB-1:0] v, input int gap_pct);
    while ($urandom_range(99) < gap_pct) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_feat  = v;
    for (int n = 0; n < 50; n++) begin
      if (bus.in_ready) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        last_acc = cyc;
        return;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("in_ready_wait", bus.in_ready, 1'b1);
  endtask

  task automatic wait_out(input bit noise, output int lat, output int pulses);
    int n;
    n      = 0;
    pulses = 0;
    while (!bus.out_valid && n < 120) begin
      if (bus.bnn_rst) pulses++;
      if (noise) begin
        bus.in_valid = 1'($urandom_range(1));
        bus.in_feat  = 4'hF;
      end
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    check("out_valid_wait", bus.out_valid, 1'b1);
    lat = cyc - last_acc;
  endtask

  task automatic hold_and_take(input int hold, input bit noise);
    for (int k = 0; k < hold; k++) begin
      if (noise) begin
        bus.in_valid = 1'($urandom_range(1));
        bus.in_feat  = 4'hF;
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: got no finish, required finish within 100000 cycles");
    $fatal(1);
  end

  initial begin
    int lat;
    int pulses;
    bus.in_valid  = 1'b0;
    bus.in_feat   = '0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_bnn_rst", bus.bnn_rst, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_features", bus.features, 48'h0);
    check("rst_done_cnt", bus.done_cnt, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back stream 0..11, then consumer stalls 20 cycles in OUT.
    for (int i = 0; i < FC; i++) begin
      send_word(FB'(i), 0);
      bus.in_valid = 1'b1;
    end
    bus.in_valid = 1'b0;
    wait_out(1'b0, lat, pulses);
    check("t1_latency", lat, 49);
    check("t1_bnn_rst_pulses", pulses, 1);
    check("t1_features", bus.features, 48'hBA9876543210);
    check("t1_out_class", bus.out_class, 3);
    check("t2_done_before", bus.done_cnt, 16'd0);
    hold_and_take(20, 1'b0);
    check("t2_done_after", bus.done_cnt, 16'd1);
    check("t2_in_ready_next", bus.in_ready, 1'b1);
    check("t2_out_valid_drop", bus.out_valid, 1'b0);

    // Stray 0xF words while busy must be ignored.
    for (int i = 0; i < FC; i++) send_word(FB'(FC - 1 - i), 0);
    wait_out(1'b1, lat, pulses);
    check("t3_features", bus.features, 48'h0123456789AB);
    hold_and_take(5, 1'b1);

    // Prediction ramps every cycle; capture must be from counter==INFER_CYCLES-1.
    pred_mode = 1;
    for (int i = 0; i < FC; i++) send_word(4'hA, 0);
    wait_out(1'b0, lat, pulses);
    check("t3_index_restart", bus.features, 48'hAAAAAAAAAAAA);
    check("t6_latency", lat, 49);
    check("t6_out_class", bus.out_class, 64'((last_acc + IC) % CC));
    hold_and_take(0, 1'b0);
    pred_mode = 0;
    check("t6_done", bus.done_cnt, 16'd3);

    // Reset in the middle of a sample.
    for (int i = 0; i < 5; i++) send_word(4'h7, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t4_out_valid", bus.out_valid, 1'b0);
    check("t4_features", bus.features, 48'h0);
    check("t4_in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < FC; i++) send_word(4'h5, 0);
    wait_out(1'b0, lat, pulses);
    check("t4_features_new", bus.features, 48'h555555555555);
    check("t4_latency", lat, 49);
    hold_and_take(2, 1'b0);
    repeat (3) @(negedge clk);
    check("t4_single_pred", bus.out_valid, 1'b0);
    check("t4_done", bus.done_cnt, 16'd1);

    // 100 random samples with 50% input gaps against the model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pred_mode = 2;
    for (int s = 0; s < 100; s++) begin
      bit noise;
      noise = 1'($urandom_range(1));
      for (int w = 0; w < FC; w++) send_word(FB'($urandom_range(15)), 50);
      wait_out(noise, lat, pulses);
      check("t5_latency", lat, 49);
      hold_and_take($urandom_range(3), noise);
    end
    @(negedge clk);
    check("t5_done_cnt", bus.done_cnt, 16'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
